// File: rtl/imem_pkg.sv
// ---------------------------------------------------------------------------
// imem_pkg
//   Shared definitions for the instruction-fetch slice: the fetch sequencer
//   state encoding, the instruction memory geometry, the halt word and the
//   redirect target calculation used by execute-driven branches and jumps.
// ---------------------------------------------------------------------------
package imem_pkg;

    localparam int          IMEM_BYTES = 256;
    localparam logic [31:0] HALT_WORD  = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    // Target = pc of the redirecting instruction + 4 + sign-extended word
    // offset scaled to bytes. Branches carry a 16-bit offset, jumps 26 bits.
    function automatic logic [31:0] redir_target(
        input logic [31:0] pc,
        input logic [25:0] imm,
        input logic        jump
    );
        logic [31:0] offset;
        if (jump) begin
            offset = {{6{imm[25]}}, imm};
        end else begin
            offset = {{16{imm[15]}}, imm[15:0]};
        end
        return pc + 32'd4 + (offset << 2);
    endfunction

endpackage

// File: rtl/imem_fetch_slot.sv
// ---------------------------------------------------------------------------
// imem_fetch_slot
//   One-entry valid/ready output register between fetch and decode.
//   A squash empties the slot, a load fills it, and otherwise a held word
//   drains when decode accepts it.
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   load           capture load_instr/load_pc and mark the slot valid
//   squash         drop the held word (wins over load)
//   load_instr     instruction word to capture
//   load_pc        byte address of load_instr
//   out_ready      decode accepts when out_valid && out_ready
//   out_valid      slot holds a valid instruction
//   out_instr      held instruction word
//   out_pc         byte address of out_instr
// ---------------------------------------------------------------------------
module imem_fetch_slot (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        squash,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    // Valid flag: a squash always empties the slot, a load always fills it,
    // and a held word leaves once decode takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (squash) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Payload only moves on a load; a squash or drain leaves the old
    // contents in place since the valid flag already hides them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_instr <= 32'd0;
            out_pc    <= 32'd0;
        end else if (load && !squash) begin
            out_instr <= load_instr;
            out_pc    <= load_pc;
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// imem_fetch_ctrl
//   Fetch sequencer for the byte-addressed instruction memory. Owns the PC,
//   presents it as the combinational read address, and registers each
//   big-endian word toward decode through a valid/ready slot. Execute
//   redirects replace the PC and squash the held word. A halt word or a bad
//   PC stops sequencing until reset.
// Configuration
//   IMEM_FETCH_PERF_EN  when defined, adds perf_fetch (words loaded) and
//                       perf_stall (FETCH cycles with if_valid && !if_ready)
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   imem_addr      read address to instruction memory (always equals pc)
//   imem_data      {mem[a],mem[a+1],mem[a+2],mem[a+3]} returned same cycle
//   if_valid       if_instr/if_pc hold a valid fetched instruction
//   if_ready       decode accepts when if_valid && if_ready
//   if_instr       registered instruction word
//   if_pc          byte address of if_instr
//   redir_valid    execute requests a redirect this cycle
//   redir_jump     0 = branch (imm[15:0]), 1 = jump (imm[25:0])
//   redir_pc       pc of the redirecting instruction
//   redir_imm      signed word offset
//   halted         halt word fetched; sticky until reset
//   fault          misaligned or out-of-range pc; sticky until reset
//   perf_fetch     (IMEM_FETCH_PERF_EN) words loaded into if_instr
//   perf_stall     (IMEM_FETCH_PERF_EN) stalled FETCH cycles
// ---------------------------------------------------------------------------
module imem_fetch_ctrl #(
    parameter int          MEM_BYTES = imem_pkg::IMEM_BYTES,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = imem_pkg::HALT_WORD
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        redir_valid,
    input  logic        redir_jump,
    input  logic [31:0] redir_pc,
    input  logic [25:0] redir_imm,
    output logic        halted,
    output logic        fault
`ifdef IMEM_FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_stall
`endif
);

    import imem_pkg::*;

    localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic         slot_load;
    logic         slot_squash;
    logic         slot_free;
    logic         pc_bad;

    assign imem_addr = pc_q;
    assign pc_bad    = (pc_q[1:0] != 2'b00) || (pc_q > LAST_PC);
    assign slot_free = !if_valid || if_ready;
    assign halted    = (state_q == HALT);
    assign fault     = (state_q == FAULT);

    // State and PC registers. HALT and FAULT are terminal, so the sticky
    // status outputs fall straight out of the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next-state logic. In FETCH a redirect outranks everything: it steers
    // the PC and squashes the slot without fetching, even if decode is
    // accepting this cycle. A bad PC is caught before any fetch attempt.
    // A halt word is swallowed rather than issued, and the PC is left
    // pointing at it.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        slot_load   = 1'b0;
        slot_squash = 1'b0;
        case (state_q)
            FETCH: begin
                if (redir_valid) begin
                    pc_d        = redir_target(redir_pc, redir_imm, redir_jump);
                    slot_squash = 1'b1;
                end else if (pc_bad) begin
                    state_d     = FAULT;
                    slot_squash = 1'b1;
                end else if (slot_free) begin
                    if (imem_data == HALT_WORD) begin
                        state_d     = HALT;
                        slot_squash = 1'b1;
                    end else begin
                        slot_load = 1'b1;
                        pc_d      = pc_q + 32'd4;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    imem_fetch_slot u_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (slot_load),
        .squash     (slot_squash),
        .load_instr (imem_data),
        .load_pc    (pc_q),
        .out_ready  (if_ready),
        .out_valid  (if_valid),
        .out_instr  (if_instr),
        .out_pc     (if_pc)
    );

`ifdef IMEM_FETCH_PERF_EN
    // Free-running performance counters; both wrap naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch <= 32'd0;
            perf_stall <= 32'd0;
        end else begin
            if (slot_load) begin
                perf_fetch <= perf_fetch + 32'd1;
            end
            if ((state_q == FETCH) && if_valid && !if_ready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_imem_fetch_ctrl
//   Self-checking bench for imem_fetch_ctrl. Directed scenarios cover the
//   reset state, sequential fetch to a halt word, stalls, redirects, faults
//   and asynchronous reset; a randomized run is compared against a
//   behavioural model built from the fetch rules. Define IMEM_FETCH_PERF_EN
//   to also check the performance counters.
// ---------------------------------------------------------------------------
module tb_imem_fetch_ctrl;

    localparam int          MEM  = 256;
    localparam logic [31:0] HWRD = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        redir_valid;
    logic        redir_jump;
    logic [31:0] redir_pc;
    logic [25:0] redir_imm;
    logic        halted;
    logic        fault;
`ifdef IMEM_FETCH_PERF_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_stall;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [0:MEM-1];

    always #5 clk = ~clk;

    // Combinational big-endian read; out-of-range addresses read zero.
    assign imem_data = (imem_addr <= 32'(MEM - 4)) ?
        {mem[imem_addr[7:0]], mem[imem_addr[7:0] + 8'd1],
         mem[imem_addr[7:0] + 8'd2], mem[imem_addr[7:0] + 8'd3]} : 32'd0;

    imem_fetch_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .redir_valid (redir_valid),
        .redir_jump  (redir_jump),
        .redir_pc    (redir_pc),
        .redir_imm   (redir_imm),
        .halted      (halted),
        .fault       (fault)
`ifdef IMEM_FETCH_PERF_EN
        ,
        .perf_fetch  (perf_fetch),
        .perf_stall  (perf_stall)
`endif
    );

    // ---------------- behavioural reference model ----------------
    logic [31:0] m_pc, m_instr, m_ipc, m_fetch, m_stall;
    bit          m_valid, m_halted, m_fault;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {mem[a[7:0]], mem[a[7:0] + 8'd1], mem[a[7:0] + 8'd2], mem[a[7:0] + 8'd3]};
    endfunction

    task automatic model_reset();
        m_pc = 32'd0; m_instr = 32'd0; m_ipc = 32'd0;
        m_valid = 1'b0; m_halted = 1'b0; m_fault = 1'b0;
        m_fetch = 32'd0; m_stall = 32'd0;
    endtask

    task automatic model_step();
        longint off;
        longint tgt;
        if (!m_halted && !m_fault) begin
            if (m_valid && !if_ready) m_stall = m_stall + 32'd1;
            if (redir_valid) begin
                if (redir_jump) begin
                    off = longint'(redir_imm);
                    if (off >= 64'sd33554432) off = off - 64'sd67108864;
                end else begin
                    off = longint'(redir_imm[15:0]);
                    if (off >= 64'sd32768) off = off - 64'sd65536;
                end
                tgt = longint'(redir_pc) + 4 + off * 4;
                m_pc = tgt[31:0];
                m_valid = 1'b0;
            end else if ((m_pc % 4) != 0 || m_pc > 32'(MEM - 4)) begin
                m_fault = 1'b1;
                m_valid = 1'b0;
            end else if (!m_valid || if_ready) begin
                if (mem_word(m_pc) == HWRD) begin
                    m_halted = 1'b1;
                    m_valid = 1'b0;
                end else begin
                    m_instr = mem_word(m_pc);
                    m_ipc = m_pc;
                    m_valid = 1'b1;
                    m_pc = m_pc + 32'd4;
                    m_fetch = m_fetch + 32'd1;
                end
            end
        end else if (if_ready) begin
            m_valid = 1'b0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    // ---------------- stimulus helpers ----------------
    task automatic fill_mem(input int halt_odds);
        logic [31:0] w;
        for (int a = 0; a < MEM; a += 4) begin
            w = $urandom;
            if (w == HWRD) w = 32'h1234_5678;
            if (halt_odds > 0 && $urandom_range(0, halt_odds - 1) == 0) w = HWRD;
            {mem[a], mem[a + 1], mem[a + 2], mem[a + 3]} = w;
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redir_valid = 1'b0;
        redir_jump = 1'b0;
        redir_pc = 32'd0;
        redir_imm = 26'd0;
        if_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic redirect(input logic jump, input logic [31:0] rpc, input logic [25:0] imm);
        redir_valid = 1'b1;
        redir_jump = jump;
        redir_pc = rpc;
        redir_imm = imm;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        if_ready = 1'b1;
        redir_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%0b exp=0", if_valid); end
        checks++; if (if_instr !== 32'd0) begin errors++; $display("[TB] FAIL reset_instr got=%h exp=0", if_instr); end
        checks++; if (if_pc !== 32'd0) begin errors++; $display("[TB] FAIL reset_pc got=%h exp=0", if_pc); end
        checks++; if (halted !== 1'b0 || fault !== 1'b0) begin errors++; $display("[TB] FAIL reset_status got=%0b%0b exp=00", halted, fault); end
        checks++; if (imem_addr !== 32'd0) begin errors++; $display("[TB] FAIL reset_addr got=%h exp=0", imem_addr); end
`ifdef IMEM_FETCH_PERF_EN
        checks++; if (perf_fetch !== 32'd0 || perf_stall !== 32'd0) begin errors++; $display("[TB] FAIL reset_perf got=%0d/%0d exp=0/0", perf_fetch, perf_stall); end
`endif
    endtask

    task automatic test_sequential();
        fill_mem(0);
        {mem[16], mem[17], mem[18], mem[19]} = HWRD;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (if_valid !== 1'b1 || if_pc !== 32'(i * 4)) begin errors++; $display("[TB] FAIL seq_pc got=%0b/%0d exp=1/%0d", if_valid, if_pc, i * 4); end
            checks++; if (if_instr !== mem_word(32'(i * 4))) begin errors++; $display("[TB] FAIL seq_instr got=%h exp=%h", if_instr, mem_word(32'(i * 4))); end
            checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL seq_early_halt got=%0b exp=0", halted); end
        end
        step();
        checks++; if (halted !== 1'b1 || if_valid !== 1'b0) begin errors++; $display("[TB] FAIL seq_halt got=%0b/%0b exp=1/0", halted, if_valid); end
        step();
        checks++; if (halted !== 1'b1 || if_valid !== 1'b0) begin errors++; $display("[TB] FAIL seq_halt_hold got=%0b/%0b exp=1/0", halted, if_valid); end
`ifdef IMEM_FETCH_PERF_EN
        checks++; if (perf_fetch !== 32'd4) begin errors++; $display("[TB] FAIL seq_perf_fetch got=%0d exp=4", perf_fetch); end
`endif
    endtask

    task automatic test_stall();
        logic [31:0] exp_w;
`ifdef IMEM_FETCH_PERF_EN
        logic [31:0] ps0;
`endif
        fill_mem(0);
        do_reset();
        step();
        step();
        exp_w = mem_word(32'd4);
        checks++; if (if_pc !== 32'd4 || if_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_pre got=%0d/%0b exp=4/1", if_pc, if_valid); end
`ifdef IMEM_FETCH_PERF_EN
        ps0 = perf_stall;
`endif
        if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (if_valid !== 1'b1 || if_pc !== 32'd4 || if_instr !== exp_w) begin errors++; $display("[TB] FAIL stall_hold got=%0b/%0d/%h exp=1/4/%h", if_valid, if_pc, if_instr, exp_w); end
            checks++; if (imem_addr !== 32'd8) begin errors++; $display("[TB] FAIL stall_addr got=%0d exp=8", imem_addr); end
        end
`ifdef IMEM_FETCH_PERF_EN
        checks++; if (perf_stall - ps0 !== 32'd3) begin errors++; $display("[TB] FAIL stall_perf got=%0d exp=3", perf_stall - ps0); end
`endif
        if_ready = 1'b1;
        step();
        checks++; if (if_pc !== 32'd8 || if_instr !== mem_word(32'd8)) begin errors++; $display("[TB] FAIL stall_resume got=%0d exp=8", if_pc); end
    endtask

    task automatic test_redirect();
        fill_mem(0);
        do_reset();
        step();
        step();
        redirect(1'b1, 32'd48, 26'h3FFFFFA);
        step();
        redir_valid = 1'b0;
        checks++; if (if_valid !== 1'b0 || imem_addr !== 32'd28) begin errors++; $display("[TB] FAIL jump_squash got=%0b/%0d exp=0/28", if_valid, imem_addr); end
        step();
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'd28 || if_instr !== mem_word(32'd28)) begin errors++; $display("[TB] FAIL jump_target got=%0b/%0d exp=1/28", if_valid, if_pc); end
        redirect(1'b0, 32'd28, 26'h000D);
        step();
        redir_valid = 1'b0;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL branch_squash got=%0b exp=0", if_valid); end
        step();
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'd84) begin errors++; $display("[TB] FAIL branch_target got=%0b/%0d exp=1/84", if_valid, if_pc); end
        if_ready = 1'b0;
        step();
        redirect(1'b1, 32'd100, 26'd10);
        step();
        redir_valid = 1'b0;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL stalled_squash got=%0b exp=0", if_valid); end
        if_ready = 1'b1;
        step();
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'd144) begin errors++; $display("[TB] FAIL stalled_target got=%0b/%0d exp=1/144", if_valid, if_pc); end
    endtask

    task automatic test_fault();
        fill_mem(0);
        do_reset();
        step();
        redirect(1'b0, 32'd30, 26'd0);
        step();
        redir_valid = 1'b0;
        checks++; if (if_valid !== 1'b0 || fault !== 1'b0 || imem_addr !== 32'd34) begin errors++; $display("[TB] FAIL mis_redir got=%0b/%0b/%0d exp=0/0/34", if_valid, fault, imem_addr); end
        step();
        checks++; if (fault !== 1'b1 || if_valid !== 1'b0) begin errors++; $display("[TB] FAIL mis_fault got=%0b/%0b exp=1/0", fault, if_valid); end
        for (int i = 0; i < 3; i++) begin
            redirect(1'b1, 32'd0, 26'd0);
            step();
            checks++; if (fault !== 1'b1 || if_valid !== 1'b0 || imem_addr !== 32'd34) begin errors++; $display("[TB] FAIL fault_ignore got=%0b/%0b/%0d exp=1/0/34", fault, if_valid, imem_addr); end
        end
        redir_valid = 1'b0;
        do_reset();
        step();
        redirect(1'b1, 32'd248, 26'd1);
        step();
        redir_valid = 1'b0;
        step();
        checks++; if (fault !== 1'b1 || if_valid !== 1'b0) begin errors++; $display("[TB] FAIL range_fault got=%0b/%0b exp=1/0", fault, if_valid); end
    endtask

    task automatic test_end_of_mem();
        fill_mem(0);
        do_reset();
        redirect(1'b0, 32'd244, 26'd1);
        step();
        redir_valid = 1'b0;
        step();
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'd252 || fault !== 1'b0) begin errors++; $display("[TB] FAIL last_word got=%0b/%0d/%0b exp=1/252/0", if_valid, if_pc, fault); end
        step();
        checks++; if (fault !== 1'b1 || if_valid !== 1'b0) begin errors++; $display("[TB] FAIL past_end got=%0b/%0b exp=1/0", fault, if_valid); end
    endtask

    task automatic test_async_reset();
        fill_mem(0);
        do_reset();
        step();
        step();
        if_ready = 1'b0;
        step();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b0 || if_pc !== 32'd0 || if_instr !== 32'd0) begin errors++; $display("[TB] FAIL async_slot got=%0b/%h/%h exp=0/0/0", if_valid, if_pc, if_instr); end
        checks++; if (imem_addr !== 32'd0 || halted !== 1'b0 || fault !== 1'b0) begin errors++; $display("[TB] FAIL async_ctrl got=%h/%0b/%0b exp=0/0/0", imem_addr, halted, fault); end
        @(negedge clk);
        rst_n = 1'b1;
        if_ready = 1'b1;
        step();
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'd0) begin errors++; $display("[TB] FAIL async_restart got=%0b/%0d exp=1/0", if_valid, if_pc); end
    endtask

    task automatic test_random(input int cycles);
        logic [31:0] rp, tgt;
        int d;
        fill_mem(40);
        do_reset();
        for (int c = 0; c < cycles; c++) begin
            if_ready = ($urandom_range(0, 3) != 0);
            redir_valid = ($urandom_range(0, 9) == 0);
            redir_jump = 1'($urandom_range(0, 1));
            rp = 32'($urandom_range(0, 63) * 4);
            redir_pc = rp;
            if ($urandom_range(0, 7) == 0) begin
                redir_imm = 26'($urandom);
            end else begin
                tgt = 32'($urandom_range(0, 63) * 4);
                d = int'(tgt) - int'(rp) - 4;
                if (redir_jump) redir_imm = 26'(d >>> 2);
                else redir_imm = {10'($urandom), 16'(d >>> 2)};
            end
            if ((halted || fault) && $urandom_range(0, 4) == 0) begin
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
                fill_mem(40);
            end
            step();
            checks++; if (if_valid !== m_valid) begin errors++; $display("[TB] FAIL rnd_valid c=%0d got=%0b exp=%0b", c, if_valid, m_valid); end
            checks++; if (if_pc !== m_ipc || if_instr !== m_instr) begin errors++; $display("[TB] FAIL rnd_word c=%0d got=%h/%h exp=%h/%h", c, if_pc, if_instr, m_ipc, m_instr); end
            checks++; if (imem_addr !== m_pc) begin errors++; $display("[TB] FAIL rnd_addr c=%0d got=%h exp=%h", c, imem_addr, m_pc); end
            checks++; if (halted !== m_halted || fault !== m_fault) begin errors++; $display("[TB] FAIL rnd_status c=%0d got=%0b%0b exp=%0b%0b", c, halted, fault, m_halted, m_fault); end
`ifdef IMEM_FETCH_PERF_EN
            checks++; if (perf_fetch !== m_fetch || perf_stall !== m_stall) begin errors++; $display("[TB] FAIL rnd_perf c=%0d got=%0d/%0d exp=%0d/%0d", c, perf_fetch, perf_stall, m_fetch, m_stall); end
`endif
        end
        redir_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n = 1'b0;
        if_ready = 1'b1;
        redir_valid = 1'b0;
        redir_jump = 1'b0;
        redir_pc = 32'd0;
        redir_imm = 26'd0;
        fill_mem(0);
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_fault();
        test_end_of_mem();
        test_async_reset();
        test_random(600);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
